ntt_agu_k2: RTL

//  Butterfly address generation unit feeding the k2 order-translate stage.
//  On start, it walks every NTT stage l and every radix-2 butterfly j in that stage.

---
 rtl/ntt_agu_k2.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ntt_agu_k2.sv
// Butterfly address generator for the k2 order-translate stage: walks stages 0..last_stage, one index pair per cycle.
// Latency: first pair is registered on the start edge; one pair per unstalled cycle, then one flush cycle.
// Backpressure: stall holds the j/stage counters and blanks the next output cycle. Optional macro AGU_DIF_EN selects DIF stride order.
module ntt_agu_k2 #(
  parameter int D_WIDTH = 32,
  parameter int LOG_N   = 16,
  parameter int STAGE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STAGE_W-1:0] last_stage,
  input  logic               stall,
  output logic [D_WIDTH-1:0] Order_0,
  output logic [D_WIDTH-1:0] Order_1,
  output logic               r_enable_k2,
  output logic               AGU_done_k2,
  output logic [D_WIDTH-1:0] l,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int JW = LOG_N - 1;
  localparam logic [JW-1:0]      J_LAST    = '1;
  localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(LOG_N - 1);

  state_t             state;
  state_t             state_nxt;
  logic [JW-1:0]      j;
  logic [STAGE_W-1:0] stage;
  logic [STAGE_W-1:0] last_q;
  logic [STAGE_W-1:0] last_in;
  logic [STAGE_W-1:0] last_eff;
  logic               gen;
  logic               final_pair;
  logic [STAGE_W-1:0] p;
  logic [LOG_N-1:0]   jx;
  logic [LOG_N-1:0]   low_mask;
  logic [LOG_N-1:0]   idx0;
  logic [LOG_N-1:0]   idx1;

  // Out-of-range stage requests are clamped to the last real stage.
  assign last_in = (last_stage > STAGE_MAX) ? STAGE_MAX : last_stage;

  // The start edge issues pair 0 itself, so it must judge "final" against the live input.
  assign last_eff = (state == IDLE) ? last_in : last_q;

  // A pair is produced on the start edge and on every unstalled RUN edge.
  assign gen = !stall && ((state == IDLE && start) || state == RUN);

  assign final_pair = gen && (j == J_LAST) && (stage == last_eff);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = final_pair ? FLUSH : RUN;
      RUN:     if (final_pair) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy spans RUN and the flush cycle that shows the final pair.
  always_comb begin
    busy = (state != IDLE);
  end

  // Latch the clamped stage limit only when a transform is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last_q <= '0;
    else if (state == IDLE && start) last_q <= last_in;
  end

  // Butterfly/stage counters; the final pair rewinds both so IDLE always starts at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j     <= '0;
      stage <= '0;
    end else if (gen) begin
      if (j == J_LAST) begin
        j     <= '0;
        stage <= final_pair ? '0 : stage + STAGE_W'(1);
      end else begin
        j <= j + JW'(1);
      end
    end
  end

  // Index math: open a zero gap at bit p of j to get the lower index, set it for the upper.
  always_comb begin
`ifdef AGU_DIF_EN
    p = STAGE_MAX - stage;
`else
    p = stage;
`endif
    jx       = {1'b0, j};
    low_mask = (LOG_N'(1) << p) - LOG_N'(1);
    idx0     = (((jx >> p) << p) << 1) | (jx & low_mask);
    idx1     = idx0 | (LOG_N'(1) << p);
  end

  // Output register: carries a pair when one was generated, otherwise all zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Order_0     <= '0;
      Order_1     <= '0;
      l           <= '0;
      r_enable_k2 <= 1'b0;
      AGU_done_k2 <= 1'b0;
    end else if (gen) begin
      Order_0     <= D_WIDTH'(idx0);
      Order_1     <= D_WIDTH'(idx1);
      l           <= D_WIDTH'(stage);
      r_enable_k2 <= 1'b1;
      AGU_done_k2 <= final_pair;
    end else begin
      Order_0     <= '0;
      Order_1     <= '0;
      l           <= '0;
      r_enable_k2 <= 1'b0;
      AGU_done_k2 <= 1'b0;
    end
  end

endmodule
